// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared NTP pipeline definitions: opcodes, instruction field slices, sequencer states
// and the shadow-stage record used by the hazard sequencer.
package pipeline_hazard_sequencer_pkg;

    localparam logic [4:0] OP_LD     = 5'b10100;
    localparam logic [4:0] OP_ST     = 5'b10101;
    localparam logic [4:0] OP_JMP    = 5'b11000;
    localparam logic [2:0] OP_CJ_PFX = 3'b111;

    localparam int unsigned OP_MSB = 23;
    localparam int unsigned OP_LSB = 19;
    localparam int unsigned RW_MSB = 18;
    localparam int unsigned RW_LSB = 14;
    localparam int unsigned RA_MSB = 13;
    localparam int unsigned RA_LSB = 9;
    localparam int unsigned RB_MSB = 8;
    localparam int unsigned RB_LSB = 4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        MEM_WAIT
    } seq_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] op;
        logic [4:0] rw;
    } stage_t;

    function automatic logic is_cj(input logic [4:0] op);
        return op[4:2] == OP_CJ_PFX;
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // Jumps carry a target in RA/RB, not register operands.
    function automatic logic skips_dep(input logic [4:0] op);
        return (op == OP_JMP) || is_cj(op);
    endfunction

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Handshake bundle between the NTP datapath and the hazard sequencer.
interface pipeline_hazard_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [23:0]      ins;
    logic             ins_valid;
    logic             br_taken;
    logic             mem_ack;
    logic             fetch_en;
    logic             pipe_en;
    logic             bubble_ex;
    logic             flush_if;
    logic             flush_dec;
    logic             mem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ins, ins_valid, br_taken, mem_ack,
        input  fetch_en, pipe_en, bubble_ex, flush_if, flush_dec,
               mem_req, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  ins, ins_valid, br_taken, mem_ack,
        output fetch_en, pipe_en, bubble_ex, flush_if, flush_dec,
               mem_req, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// NTP 5-stage pipeline sequencer: shadows DEC/EX/DM occupancy and drives the PC and
// pipeline-register enables for load-use stalls, jump/branch flushes and memory waits.
module pipeline_hazard_sequencer
    import pipeline_hazard_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_hazard_sequencer_if.slave   bus
);

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    seq_state_t state;
    stage_t     dec_q, ex_q, dm_q;
    logic [7:0] wait_cnt;
    logic       lu_block;

    logic [4:0] ins_op, ins_rw, ins_ra, ins_rb;
    logic       unused_ins_bits;
    logic       mem_req, mem_hold, cj_taken, lu_hit;
    logic       fetch_en, pipe_en, bubble_ex, flush_if, flush_dec, mem_err;
    logic       stall_inc, flush_inc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    assign ins_op          = bus.ins[OP_MSB:OP_LSB];
    assign ins_rw          = bus.ins[RW_MSB:RW_LSB];
    assign ins_ra          = bus.ins[RA_MSB:RA_LSB];
    assign ins_rb          = bus.ins[RB_MSB:RB_LSB];
    assign unused_ins_bits = ^bus.ins[3:0];

    assign mem_req  = (state != BOOT) && dm_q.valid && is_mem(dm_q.op);
    assign mem_hold = mem_req && !bus.mem_ack;
    assign cj_taken = ex_q.valid && is_cj(ex_q.op) && bus.br_taken;
    // lu_block limits a load-use stall to one cycle while the same pair is still visible.
    assign lu_hit   = !lu_block && dec_q.valid && (dec_q.op == OP_LD) && (dec_q.rw != '0)
                      && bus.ins_valid && !skips_dep(ins_op)
                      && ((ins_ra == dec_q.rw) || (ins_rb == dec_q.rw));

    always_comb begin
        fetch_en  = 1'b0;
        pipe_en   = 1'b0;
        bubble_ex = 1'b0;
        flush_if  = 1'b0;
        flush_dec = 1'b0;
        mem_err   = 1'b0;
        case (state)
            RUN: begin
                if (mem_hold) begin
                    fetch_en = 1'b0;
                end else if (cj_taken) begin
                    fetch_en  = 1'b1;
                    pipe_en   = 1'b1;
                    flush_if  = 1'b1;
                    flush_dec = 1'b1;
                end else if (lu_hit) begin
                    pipe_en   = 1'b1;
                    bubble_ex = 1'b1;
                end else if (dec_q.valid && (dec_q.op == OP_JMP)) begin
                    fetch_en = 1'b1;
                    pipe_en  = 1'b1;
                    flush_if = 1'b1;
                end else begin
                    fetch_en = 1'b1;
                    pipe_en  = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ack) begin
                    fetch_en = 1'b1;
                    pipe_en  = 1'b1;
                end else if (wait_cnt == TO_LAST) begin
                    fetch_en = 1'b1;
                    pipe_en  = 1'b1;
                    mem_err  = 1'b1;
                end
            end
            default: begin
                fetch_en = 1'b0;
            end
        endcase
    end

    assign stall_inc = (state != BOOT) && !fetch_en;
    assign flush_inc = flush_if;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            wait_cnt <= '0;
            lu_block <= 1'b0;
            dec_q    <= '0;
            ex_q     <= '0;
            dm_q     <= '0;
        end else begin
            lu_block <= bubble_ex;
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (mem_hold) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (pipe_en) state <= RUN;
                    else         wait_cnt <= wait_cnt + 8'd1;
                end
                default: state <= BOOT;
            endcase
            if (pipe_en) begin
                dm_q <= ex_q;
                ex_q <= (bubble_ex || flush_dec) ? '0 : dec_q;
                if (fetch_en) begin
                    dec_q <= flush_if ? '0 : {bus.ins_valid, ins_op, ins_rw};
                end
            end
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (1'b0),
        .count (stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .clr   (1'b0),
        .count (flush_cnt)
    );

    assign bus.fetch_en  = fetch_en;
    assign bus.pipe_en   = pipe_en;
    assign bus.bubble_ex = bubble_ex;
    assign bus.flush_if  = flush_if;
    assign bus.flush_dec = flush_dec;
    assign bus.mem_req   = mem_req;
    assign bus.mem_err   = mem_err;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Scoreboard bench for pipeline_hazard_sequencer: a cycle-level reference model queues the
// expected outputs for every cycle and a negedge monitor compares them against the DUT.
module tb_pipeline_hazard_sequencer;

    localparam int unsigned TB_CNT_W   = 4;
    localparam int unsigned TB_TIMEOUT = 5;
    localparam int          CNT_MAX    = (1 << TB_CNT_W) - 1;

    localparam bit [4:0] T_LD  = 5'b10100;
    localparam bit [4:0] T_ST  = 5'b10101;
    localparam bit [4:0] T_JMP = 5'b11000;
    localparam bit [4:0] T_ADD = 5'b00001;
    localparam bit [4:0] T_CJ  = 5'b11101;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_sequencer_if #(.CNT_W(TB_CNT_W)) bus ();

    pipeline_hazard_sequencer #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit v;
        bit [4:0] op;
        bit [4:0] rw;
    } slot_t;

    typedef struct {
        bit fe, pe, bub, fif, fdec, mreq, merr;
        int stall, flush;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: what each pipeline slot holds, and whether the sequencer is booting,
    // running or waiting on data memory.
    slot_t m_dec, m_ex, m_dm;
    int    m_mode;          // 0 = booting, 1 = running, 2 = waiting on memory
    int    m_waited;
    bit    m_lu_done;
    int    m_stalls, m_flushes;
    bit    last_fe;

    task automatic model_reset();
        m_dec = '{default: 0};
        m_ex  = '{default: 0};
        m_dm  = '{default: 0};
        m_mode = 0;
        m_waited = 0;
        m_lu_done = 0;
        m_stalls = 0;
        m_flushes = 0;
    endtask

    function automatic bit load_use(input logic [23:0] ins, input logic iv);
        bit [4:0] op, ra, rb;
        op = ins[23:19];
        ra = ins[13:9];
        rb = ins[8:4];
        if (!iv || !m_dec.v || m_dec.op != T_LD || m_dec.rw == 0) return 0;
        if (op == T_JMP || op[4:2] == 3'b111) return 0;
        return (ra == m_dec.rw) || (rb == m_dec.rw);
    endfunction

    task automatic model_cycle(input logic [23:0] ins, input logic iv, input logic br,
                               input logic ack, output exp_t e);
        bit adv, fetch, kill_if, kill_ex, mem_busy, booting;
        slot_t nop;
        nop = '{default: 0};
        e = '{default: 0};
        e.stall = m_stalls;
        e.flush = m_flushes;
        mem_busy = m_dm.v && (m_dm.op == T_LD || m_dm.op == T_ST);
        e.mreq = mem_busy;
        adv = 0; fetch = 0; kill_if = 0; kill_ex = 0;
        booting = (m_mode == 0);
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (mem_busy && !ack) begin
                m_mode = 2;
                m_waited = 0;
            end else begin
                adv = 1; fetch = 1;
                if (m_ex.v && m_ex.op[4:2] == 3'b111 && br) begin
                    kill_if = 1; kill_ex = 1; e.fdec = 1;
                end else if (!m_lu_done && load_use(ins, iv)) begin
                    fetch = 0; kill_ex = 1; e.bub = 1;
                end else if (m_dec.v && m_dec.op == T_JMP) begin
                    kill_if = 1;
                end
            end
        end else begin
            m_waited++;
            if (ack) begin
                adv = 1; fetch = 1; m_mode = 1;
            end else if (m_waited == TB_TIMEOUT) begin
                adv = 1; fetch = 1; e.merr = 1; m_mode = 1;
            end
        end
        e.fe = fetch;
        e.pe = adv;
        e.fif = kill_if;
        if (!booting && !fetch && m_stalls < CNT_MAX) m_stalls++;
        if (kill_if && m_flushes < CNT_MAX) m_flushes++;
        m_lu_done = e.bub;
        if (adv) begin
            m_dm = m_ex;
            m_ex = kill_ex ? nop : m_dec;
            if (fetch) m_dec = kill_if ? nop : '{v: iv, op: ins[23:19], rw: ins[18:14]};
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic rst_checks();
        chk("rst_fetch_en", int'(bus.fetch_en), 0);
        chk("rst_pipe_en", int'(bus.pipe_en), 0);
        chk("rst_bubble_ex", int'(bus.bubble_ex), 0);
        chk("rst_flush_if", int'(bus.flush_if), 0);
        chk("rst_flush_dec", int'(bus.flush_dec), 0);
        chk("rst_mem_req", int'(bus.mem_req), 0);
        chk("rst_mem_err", int'(bus.mem_err), 0);
        chk("rst_stall_cnt", int'(bus.stall_cnt), 0);
        chk("rst_flush_cnt", int'(bus.flush_cnt), 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("fetch_en", int'(bus.fetch_en), int'(e.fe));
                chk("pipe_en", int'(bus.pipe_en), int'(e.pe));
                chk("bubble_ex", int'(bus.bubble_ex), int'(e.bub));
                chk("flush_if", int'(bus.flush_if), int'(e.fif));
                chk("flush_dec", int'(bus.flush_dec), int'(e.fdec));
                chk("mem_req", int'(bus.mem_req), int'(e.mreq));
                chk("mem_err", int'(bus.mem_err), int'(e.merr));
                chk("stall_cnt", int'(bus.stall_cnt), e.stall);
                chk("flush_cnt", int'(bus.flush_cnt), e.flush);
            end
        end
    end

    function automatic logic [23:0] mk(input bit [4:0] op, input bit [4:0] rw,
                                       input bit [4:0] ra, input bit [4:0] rb);
        return {op, rw, ra, rb, 4'b0000};
    endfunction

    function automatic logic [23:0] rand_ins();
        bit [4:0] op;
        int unsigned k;
        k = $urandom_range(0, 9);
        case (k)
            0, 1:    op = T_LD;
            2:       op = T_ST;
            3:       op = T_JMP;
            4:       op = {3'b111, 2'($urandom)};
            default: op = 5'($urandom_range(0, 15));
        endcase
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 4'($urandom)};
    endfunction

    logic [23:0] dir_q[$];
    logic [23:0] cur;
    int          ack_hold;

    function automatic logic [23:0] next_ins();
        if (dir_q.size() != 0) return dir_q.pop_front();
        return rand_ins();
    endfunction

    task automatic step(input logic iv, input logic br, input logic ack);
        exp_t e;
        bus.ins       = cur;
        bus.ins_valid = iv;
        bus.br_taken  = br;
        bus.mem_ack   = ack;
        model_cycle(cur, iv, br, ack, e);
        exp_q.push_back(e);
        last_fe = e.fe;
        @(posedge clk);
        #1;
        if (last_fe) cur = next_ins();
    endtask

    task automatic rand_step();
        logic ack;
        if (ack_hold > 0) begin
            ack = 1'b0;
            ack_hold--;
        end else if ($urandom_range(0, 7) == 0) begin
            ack = 1'b0;
            ack_hold = $urandom_range(1, 8);
        end else begin
            ack = ($urandom_range(0, 3) != 0);
        end
        step($urandom_range(0, 9) != 0, 1'($urandom), ack);
    endtask

    initial begin
        reset = 1'b1;
        bus.ins = '0;
        bus.ins_valid = 1'b0;
        bus.br_taken = 1'b0;
        bus.mem_ack = 1'b0;
        ack_hold = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_checks();
        dir_q = '{mk(T_ADD, 5'd5, 5'd3, 5'd4), mk(T_ADD, 5'd6, 5'd1, 5'd2),
                  mk(T_LD, 5'd0, 5'd1, 5'd1), mk(T_ADD, 5'd1, 5'd0, 5'd0),
                  mk(T_LD, 5'd3, 5'd1, 5'd1), mk(T_JMP, 5'd0, 5'd3, 5'd3),
                  mk(T_ADD, 5'd2, 5'd1, 5'd1), mk(T_CJ, 5'd0, 5'd1, 5'd1),
                  mk(T_LD, 5'd2, 5'd1, 5'd1), mk(T_ADD, 5'd7, 5'd2, 5'd1),
                  mk(T_ADD, 5'd1, 5'd1, 5'd1), mk(T_ST, 5'd1, 5'd2, 5'd2),
                  mk(T_ADD, 5'd1, 5'd1, 5'd1), mk(T_ADD, 5'd1, 5'd1, 5'd1)};
        cur = mk(T_LD, 5'd3, 5'd1, 5'd1);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);
        // Long ack-free windows so the store/load in DM both waits and times out.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
        for (int seg = 0; seg < 6; seg++) begin
            int unsigned len;
            len = $urandom_range(40, 90);
            for (int unsigned i = 0; i < len; i++) rand_step();
            reset = 1'b1;
            #1;
            rst_checks();
            model_reset();
            ack_hold = 0;
            @(posedge clk);
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
        for (int i = 0; i < 30; i++) rand_step();
        if (exp_q.size() != 0) begin
            chk("scoreboard_drain", exp_q.size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
